// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module     : uart_pkg
// Description: Shared types and constants for the 16x oversampling UART
//              receiver: FSM state encoding, oversample rate, per-bit
//              sample positions and the tick divider helper.
// Revision   : 1.0 - initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } state_t;

  localparam int OVS     = 16;
  // Three samples around the bit centre are voted.
  localparam int SMP_LO  = 7;
  localparam int SMP_MID = 8;
  localparam int SMP_HI  = 9;

  // Rounded clk cycles per oversample tick.
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + (baud * OVS) / 2) / (baud * OVS);
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ovs_tick_gen.sv
`default_nettype none
// ============================================================================
// Module     : ovs_tick_gen
// Description: Oversample tick generator. Counts 0..DIV-1 and pulses tick
//              when the count reaches DIV-1. Held at zero while clr is high
//              so the tick phase restarts on every frame.
// Ports      : clk   - system clock
//              rst_n - asynchronous active-low reset
//              clr   - synchronous clear / hold
//              tick  - one-clk pulse every DIV cycles
// Revision   : 1.0 - initial release
// ============================================================================
module ovs_tick_gen #(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = !clr && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_rx_ovs.sv
`default_nettype none
// ============================================================================
// Module     : uart_rx_ovs
// Description: 16x oversampling 8N1 UART receiver running on the system
//              clock. Validates the start bit, majority-votes three samples
//              per bit and reports each byte with a one-clk ok strobe or a
//              one-clk frame_err strobe when the stop bit is low.
// Ports      : clk       - system clock
//              rst_n     - asynchronous active-low reset
//              mosi      - raw serial line, idle high, asynchronous
//              data      - last correctly received byte
//              ok        - one-clk pulse, data valid in the same cycle
//              frame_err - one-clk pulse, stop bit sampled low
//              busy      - high from start-edge detection until IDLE
// Revision   : 1.0 - initial release
// ============================================================================
module uart_rx_ovs
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       mosi,
  output logic [7:0] data,
  output logic       ok,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);

  state_t     state;
  logic [1:0] sync;
  logic       rx_s;
  logic       rx_prev;
  // seen[1] marks that rx_s holds a real line sample rather than the
  // reset preset; armed is set once such a sample has been high, so a
  // line that is already low at reset release never looks like an edge.
  logic [1:0] seen;
  logic       armed;
  logic [3:0] sc;
  logic [2:0] bc;
  logic       s_lo;
  logic       s_mid;
  logic       vote;
  logic [7:0] shift;
  logic       tick;

  assign rx_s = sync[1];
  assign vote = maj3(s_lo, s_mid, rx_s);

  ovs_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state == IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync      <= 2'b11;
      rx_prev   <= 1'b1;
      seen      <= 2'b00;
      armed     <= 1'b0;
      state     <= IDLE;
      sc        <= '0;
      bc        <= '0;
      s_lo      <= 1'b0;
      s_mid     <= 1'b0;
      shift     <= '0;
      data      <= '0;
      ok        <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sync      <= {sync[0], mosi};
      rx_prev   <= rx_s;
      seen      <= {seen[0], 1'b1};
      if (seen[1] && rx_s) armed <= 1'b1;
      ok        <= 1'b0;
      frame_err <= 1'b0;

      case (state)
        IDLE: begin
          sc <= '0;
          bc <= '0;
          if (armed && rx_prev && !rx_s) begin
            state <= START;
            busy  <= 1'b1;
          end
        end

        START: if (tick) begin
          sc <= sc + 1'b1;
          if (sc == 4'(SMP_LO) && rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (sc == 4'(OVS - 1)) begin
            state <= DATA;
            bc    <= '0;
          end
        end

        DATA: if (tick) begin
          sc <= sc + 1'b1;
          if (sc == 4'(SMP_LO))  s_lo  <= rx_s;
          if (sc == 4'(SMP_MID)) s_mid <= rx_s;
          if (sc == 4'(SMP_HI))  shift[bc] <= vote;
          if (sc == 4'(OVS - 1)) begin
            if (bc == 3'd7) state <= STOP;
            else            bc    <= bc + 1'b1;
          end
        end

        // Decide at the centre of the stop bit so the next start edge,
        // even with no idle gap, is seen from IDLE.
        STOP: if (tick) begin
          sc <= sc + 1'b1;
          if (sc == 4'(SMP_LO))  s_lo  <= rx_s;
          if (sc == 4'(SMP_MID)) s_mid <= rx_s;
          if (sc == 4'(SMP_HI)) begin
            if (vote) begin
              data  <= shift;
              ok    <= 1'b1;
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end

        BREAK: if (rx_s) begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ovs.sv
`default_nettype none
// ============================================================================
// Module     : tb_uart_rx_ovs
// Description: Self-checking bench for uart_rx_ovs at 160 clk per bit.
//              Frames are driven one clock at a time; every pulse seen on
//              ok/frame_err is matched against a queue of expected results.
// Revision   : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_ovs;

  localparam int CLK_HZ  = 1600000;
  localparam int BAUD    = 10000;
  localparam int BIT_CLK = 160;
  localparam int LAT_MIN = 1500;
  localparam int LAT_MAX = 1560;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       mosi  = 1'b1;
  logic [7:0] data;
  logic       ok;
  logic       frame_err;
  logic       busy;

  uart_rx_ovs #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mosi      (mosi),
    .data      (data),
    .ok        (ok),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         fall;
  } exp_t;

  exp_t       sbq[$];
  int         checks     = 0;
  int         errors     = 0;
  int         cyc        = 0;
  logic       prev_pulse = 1'b0;
  logic [7:0] last_good  = 8'h00;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample outputs at the negedge, then drive the line.
  task automatic step(input logic m);
    exp_t e;
    int   lat;
    @(negedge clk);
    if (ok || frame_err) begin
      check("ok_fe_exclusive", 32'(ok & frame_err), 32'd0);
      check("pulse_single_clk", 32'(prev_pulse), 32'd0);
      if (sbq.size() == 0) begin
        check("unexpected_pulse", {30'd0, ok, frame_err}, 32'd0);
      end else begin
        e = sbq.pop_front();
        check("pulse_kind_fe", 32'(frame_err), 32'(e.is_err));
        if (ok) begin
          lat = cyc - e.fall;
          check($sformatf("ok_data lat=%0d", lat), 32'(data), 32'(e.data));
          check($sformatf("ok_latency_window lat=%0d", lat),
                32'(lat >= LAT_MIN && lat <= LAT_MAX), 32'd1);
          last_good = e.data;
        end else begin
          check("fe_data_held", 32'(data), 32'(last_good));
        end
      end
    end
    prev_pulse = ok | frame_err;
    mosi = m;
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1);
  endtask

  // Drives a 10-bit frame. glitch_at inverts the line for one clk at that
  // frame-relative cycle; abort_at stops driving early (no result expected).
  task automatic send(input logic [7:0] b, input logic stop_bit,
                      input int glitch_at, input int abort_at);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    if (abort_at < 0) sbq.push_back('{is_err: !stop_bit, data: b, fall: cyc});
    for (int c = 0; c < 10 * BIT_CLK; c++) begin
      if (c == abort_at) return;
      step(bits[c / BIT_CLK] ^ (c == glitch_at));
    end
  endtask

  initial begin
    int n;
    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data), 32'h00);
    check("rst_ok", 32'(ok), 32'd0);
    check("rst_fe", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    idle(20);

    // Single byte with latency check
    send(8'hA5, 1'b1, -1, -1);
    idle(100);
    check("a5_data_after", 32'(data), 32'hA5);

    // Back-to-back frames, zero idle
    send(8'h00, 1'b1, -1, -1);
    send(8'hFF, 1'b1, -1, -1);
    send(8'h3C, 1'b1, -1, -1);
    idle(100);

    // Framing error, line held low three bit times
    send(8'h55, 1'b0, -1, -1);
    for (int i = 0; i < 3 * BIT_CLK; i++) step(1'b0);
    check("break_busy_high", 32'(busy), 32'd1);
    check("break_data_held", 32'(data), 32'h3C);
    idle(5);
    check("break_busy_released", 32'(busy), 32'd0);
    idle(50);
    send(8'h12, 1'b1, -1, -1);
    idle(100);

    // False start: 40 clk low pulse
    repeat (20) step(1'b0);
    check("false_start_busy", 32'(busy), 32'd1);
    repeat (20) step(1'b0);
    repeat (60) step(1'b1);
    check("false_start_abort", 32'(busy), 32'd0);
    idle(100);
    send(8'h81, 1'b1, -1, -1);
    idle(100);

    // One-clk high glitch at the middle sample of bit 3
    send(8'h00, 1'b1, 730, -1);
    idle(100);

    // Reset during bit 4 with the line held low through release
    send(8'hC3, 1'b1, -1, 880);
    mosi  = 1'b0;
    rst_n = 1'b0;
    repeat (5) step(1'b0);
    check("midreset_data", 32'(data), 32'h00);
    last_good = 8'h00;
    rst_n = 1'b1;
    repeat (200) step(1'b0);
    check("midreset_busy", 32'(busy), 32'd0);
    idle(50);
    send(8'h7E, 1'b1, -1, -1);
    idle(100);

    // Drain anything still outstanding, bounded
    n = 0;
    while (sbq.size() != 0 && n < 5000) begin
      step(1'b1);
      n++;
    end
    check("scoreboard_drained", 32'(sbq.size()), 32'd0);
    check("final_data", 32'(data), 32'h7E);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
